digit_sprite_renderer: RTL and testbench
========================================

# digit_sprite_renderer

Pixel-pipeline stage directly upstream of the 20x20 digit sprite ROMs: converts the current VGA raster coordinate into a ROM address, absorbs the ROM's one-cycle read latency, and produces a masked 8-bit pixel plus a valid flag for the colour mux. The on-screen position of the digit is updated through a load/ack handshake and applied only at frame start, so a moving sprite never tears.

## Interface
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 20, sprite height in pixels
- TRANSPARENT, 8'h00, ROM pixel value treated as see-through
- INIT_X, 10'd310, reset sprite left edge
- INIT_Y, 10'd230, reset sprite top edge

- i_clk2  input  1  pixel clock, shared with the sprite ROM
- i_rst  input  1  reset, synchronous, active-high
- i_x  input  10  current raster column
- i_y  input  10  current raster row
- i_active  input  1  raster inside visible area
- i_frame_start  input  1  one-cycle pulse at first pixel of frame
- i_pos_load  input  1  request to move sprite
- i_pos_x  input  10  requested left edge, sampled with i_pos_load
- i_pos_y  input  10  requested top edge, sampled with i_pos_load
- o_pos_ack  output  1  one-cycle acknowledge of i_pos_load
- o_numberaddr  output  10  ROM address (row*SPRITE_W + col)
- i_numberdata  input  8  ROM read data, valid one cycle after address
- o_pixel  output  8  sprite pixel, 0 when not valid
- o_pixel_valid  output  1  pixel is inside sprite and not TRANSPARENT

## Operation
- Registers: cur_x/cur_y (live position), pend_x/pend_y, state {IDLE, PENDING}.
- Handshake: i_pos_load samples i_pos_x/y into pend_*, asserts o_pos_ack next cycle for one cycle, state -> PENDING. Load while PENDING overwrites pend_* and acks again.
- PENDING & i_frame_start: cur_* <= pend_*, state -> IDLE. Same-cycle i_pos_load: the old pend_* is applied, new request is captured into pend_*, state stays PENDING.
- Hit test (stage 0, combinational from registered cur_*): in_box = i_active & i_x >= cur_x & i_x < cur_x+SPRITE_W & same for y; compare in 11 bits so cur_x near 639 never wraps.
- Address: col = i_x-cur_x, row = i_y-cur_y; addr = row*20+col via (row<<4)+(row<<2)+col; range 0..399. Out of box: address 0.
- Output: o_pixel_valid = in_box delayed 2 & (i_numberdata != TRANSPARENT); o_pixel = i_numberdata when valid, else 0.

## Timing
- Stage 1 (cycle N+1): o_numberaddr and in_box_d1 registered from coordinate at cycle N.
- Stage 2 (cycle N+2): ROM data arrives; o_pixel/o_pixel_valid registered from it and in_box_d2. Total latency 2 cycles; upstream delays sync by 2.
- Position change takes effect for the coordinate presented in the i_frame_start cycle.
- Reset: cur_* = INIT_*, pend_* = 0, state IDLE, o_pos_ack 0, o_numberaddr 0, o_pixel 0, o_pixel_valid 0, pipeline valids cleared. Reset mid-request discards the pending position and no ack is issued.
- i_active low forces in_box 0 regardless of coordinate.

## Structure
- Shared package: SPRITE_W/H, TRANSPARENT, address width (10), screen width/height constants (640/480).
- One natural sub-module: sprite_pos_latch (handshake FSM + cur/pend registers); the pipeline stays in the top.

## Test plan
- Reset, cur=(310,230): raster (310,230) -> o_numberaddr=0 at N+1; raster (329,249) -> addr 399; raster (330,230) -> o_pixel_valid=0 at N+2.
- ROM model returns 8'h00 at addr 5, 8'hE0 elsewhere: pixel (315,230) -> o_pixel_valid=0; (316,230) -> o_pixel=8'hE0, valid=1 exactly 2 cycles later.
- i_pos_load (100,50) mid-frame -> o_pos_ack one cycle; sprite still at (310,230) until i_frame_start, then (100,50) hits addr 0.
- Two loads (100,50) then (200,60) before frame start -> two acks; after frame start only (200,60) is live.
- i_pos_load (400,400) in same cycle as i_frame_start with pending (100,50) -> (100,50) applied now, (400,400) applied at next frame start.
- cur_x=630: raster x=639 -> in box, addr col 9; x=0 on same row -> not in box (no wrap); i_rst asserted while PENDING -> cur returns to (310,230), no ack.

Source files
------------

// File: rtl/digit_sprite_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_sprite_renderer_pkg
//  Description : Shared constants and types for the digit sprite renderer:
//                sprite geometry, transparent colour key, coordinate and ROM
//                address widths, screen size, and the position-latch states.
//  Revision    : 1.0  initial release
// ============================================================================
package digit_sprite_renderer_pkg;

    localparam int          SPRITE_W_DEF    = 20;
    localparam int          SPRITE_H_DEF    = 20;
    localparam logic [7:0]  TRANSPARENT_DEF = 8'h00;

    localparam int          COORD_W         = 10;
    localparam int          ADDR_W          = 10;
    localparam int          PIX_W           = 8;

    localparam int          SCREEN_W        = 640;
    localparam int          SCREEN_H        = 480;

    typedef enum logic [0:0] {
        POS_IDLE    = 1'b0,
        POS_PENDING = 1'b1
    } pos_state_t;

endpackage : digit_sprite_renderer_pkg
`default_nettype wire

// File: rtl/digit_sprite_renderer_sprite_pos_latch.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pos_latch
//  Description : Load/ack handshake for the sprite position. A load captures
//                the requested position into a pending register and is
//                acknowledged one cycle later. The pending position becomes
//                live only on a frame-start pulse, so the sprite never tears.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                frame_start       - one-cycle pulse at first pixel of frame
//                pos_load/x/y      - position request and its coordinates
//                pos_ack           - one-cycle acknowledge of pos_load
//                eff_x/eff_y       - position to use for the current pixel
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_pos_latch
    import digit_sprite_renderer_pkg::*;
#(
    parameter logic [COORD_W-1:0] INIT_X = 10'd310,
    parameter logic [COORD_W-1:0] INIT_Y = 10'd230
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pos_load,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               pos_ack,
    output logic [COORD_W-1:0] eff_x,
    output logic [COORD_W-1:0] eff_y
);

    pos_state_t         state;
    pos_state_t         next_state;
    logic               apply;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;

    // A load in the same cycle as the apply keeps the latch pending: the
    // older request goes live now, the newer one waits for the next frame.
    always_comb begin
        next_state = state;
        apply      = 1'b0;
        if ((state == POS_PENDING) && frame_start) begin
            apply      = 1'b1;
            next_state = POS_IDLE;
        end
        if (pos_load) begin
            next_state = POS_PENDING;
        end
    end

    // Bypass so the pixel presented with frame_start already uses the new
    // position; otherwise the first pixel of the frame would be stale.
    assign eff_x = apply ? pend_x : cur_x;
    assign eff_y = apply ? pend_y : cur_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= POS_IDLE;
            cur_x   <= INIT_X;
            cur_y   <= INIT_Y;
            pend_x  <= '0;
            pend_y  <= '0;
            pos_ack <= 1'b0;
        end else begin
            state   <= next_state;
            pos_ack <= pos_load;
            if (apply) begin
                cur_x <= pend_x;
                cur_y <= pend_y;
            end
            if (pos_load) begin
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
        end
    end

endmodule : sprite_pos_latch
`default_nettype wire

// File: rtl/digit_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : digit_sprite_renderer
//  Description : Converts the raster coordinate into a 20x20 sprite ROM
//                address, absorbs the ROM's one-cycle read latency and
//                delivers a colour-keyed pixel with a valid flag.
//  Ports       : i_clk2, i_rst           - pixel clock, sync active-high reset
//                i_x, i_y, i_active      - raster coordinate and visibility
//                i_frame_start           - first pixel of frame pulse
//                i_pos_load/x/y, o_pos_ack - sprite move handshake
//                o_numberaddr, i_numberdata - sprite ROM address / read data
//                o_pixel, o_pixel_valid  - masked pixel output (latency 2)
//  Revision    : 1.0  initial release
// ============================================================================
module digit_sprite_renderer
    import digit_sprite_renderer_pkg::*;
#(
    parameter int                 SPRITE_W    = SPRITE_W_DEF,
    parameter int                 SPRITE_H    = SPRITE_H_DEF,
    parameter logic [PIX_W-1:0]   TRANSPARENT = TRANSPARENT_DEF,
    parameter logic [COORD_W-1:0] INIT_X      = 10'd310,
    parameter logic [COORD_W-1:0] INIT_Y      = 10'd230
) (
    input  logic               i_clk2,
    input  logic               i_rst,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_active,
    input  logic               i_frame_start,
    input  logic               i_pos_load,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    output logic               o_pos_ack,
    output logic [ADDR_W-1:0]  o_numberaddr,
    input  logic [PIX_W-1:0]   i_numberdata,
    output logic [PIX_W-1:0]   o_pixel,
    output logic               o_pixel_valid
);

    logic [COORD_W-1:0] eff_x;
    logic [COORD_W-1:0] eff_y;
    logic [COORD_W:0]   x_ext;
    logic [COORD_W:0]   y_ext;
    logic [COORD_W:0]   left_ext;
    logic [COORD_W:0]   top_ext;
    logic               in_box;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [ADDR_W-1:0]  addr_next;
    logic               in_box_d1;
    logic               in_box_d2;

    sprite_pos_latch #(
        .INIT_X (INIT_X),
        .INIT_Y (INIT_Y)
    ) u_pos_latch (
        .clk         (i_clk2),
        .rst         (i_rst),
        .frame_start (i_frame_start),
        .pos_load    (i_pos_load),
        .pos_x       (i_pos_x),
        .pos_y       (i_pos_y),
        .pos_ack     (o_pos_ack),
        .eff_x       (eff_x),
        .eff_y       (eff_y)
    );

    // Box edges are compared one bit wider so a sprite near the right or
    // bottom edge cannot wrap its far edge back past zero.
    assign x_ext    = {1'b0, i_x};
    assign y_ext    = {1'b0, i_y};
    assign left_ext = {1'b0, eff_x};
    assign top_ext  = {1'b0, eff_y};

    assign in_box = i_active
                  && (x_ext >= left_ext) && (x_ext < left_ext + 11'(SPRITE_W))
                  && (y_ext >= top_ext)  && (y_ext < top_ext  + 11'(SPRITE_H));

    assign col = i_x - eff_x;
    assign row = i_y - eff_y;

    // Constant multiply by the sprite width; for 20 this reduces to
    // (row<<4)+(row<<2). Only meaningful inside the box, so gate to 0.
    assign addr_next = in_box ? (row * 10'(SPRITE_W) + col) : '0;

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            o_numberaddr <= '0;
            in_box_d1    <= 1'b0;
            in_box_d2    <= 1'b0;
        end else begin
            o_numberaddr <= addr_next;
            in_box_d1    <= in_box;
            in_box_d2    <= in_box_d1;
        end
    end

    // The ROM registers the address issued in stage 1, so its data and
    // in_box_d2 are both register outputs aligned in stage 2; the key/mask
    // is applied directly to them to keep total latency at two cycles.
    assign o_pixel_valid = in_box_d2 && (i_numberdata != TRANSPARENT);
    assign o_pixel       = o_pixel_valid ? i_numberdata : '0;

endmodule : digit_sprite_renderer
`default_nettype wire

// File: tb/tb_digit_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_sprite_renderer
//  Description : Self-checking bench for digit_sprite_renderer. Directed
//                scenarios followed by randomized traffic, compared against
//                a per-cycle reference model of sprite position and pixel
//                history.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_digit_sprite_renderer;

    localparam int INIT_X = 310;
    localparam int INIT_Y = 230;
    localparam int SW     = 20;
    localparam int SH     = 20;
    localparam int HMAX   = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       active = 1'b0;
    logic       frame_start = 1'b0;
    logic       pos_load = 1'b0;
    logic [9:0] pos_x = '0;
    logic [9:0] pos_y = '0;
    logic       pos_ack;
    logic [9:0] numberaddr;
    logic [7:0] numberdata = 8'h00;
    logic [7:0] pixel;
    logic       pixel_valid;

    always #5 clk = ~clk;

    digit_sprite_renderer dut (
        .i_clk2        (clk),
        .i_rst         (rst),
        .i_x           (x),
        .i_y           (y),
        .i_active      (active),
        .i_frame_start (frame_start),
        .i_pos_load    (pos_load),
        .i_pos_x       (pos_x),
        .i_pos_y       (pos_y),
        .o_pos_ack     (pos_ack),
        .o_numberaddr  (numberaddr),
        .i_numberdata  (numberdata),
        .o_pixel       (pixel),
        .o_pixel_valid (pixel_valid)
    );

    // ROM contents: transparent at address 5, 0xE0 on multiples of 3,
    // a varied pattern elsewhere (which is occasionally also transparent).
    function automatic logic [7:0] rom_val(input int a);
        if (a == 5)     return 8'h00;
        if (a % 3 == 0) return 8'hE0;
        return 8'((a * 13) & 255);
    endfunction

    always @(posedge clk) numberdata <= rom_val(int'(numberaddr));

    // Reference model state
    int m_cur_x = INIT_X, m_cur_y = INIT_Y;
    int m_pend_x = 0, m_pend_y = 0;
    bit m_pending = 1'b0;

    // Per-cycle history: coordinate hit, expected address, load, reset
    bit h_in  [HMAX];
    int h_addr[HMAX];
    bit h_ld  [HMAX];
    bit h_rst [HMAX];

    int t = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, t);
    endtask

    // One pixel clock: check outputs due now, drive this cycle's inputs,
    // update the model, then advance to just after the next rising edge.
    task automatic step(input int sx, input int sy, input bit sact, input bit sfs,
                        input bit sld, input int spx, input int spy, input bit srst);
        int ex, ey, d, ea;
        bit hit, ev;
        if (t >= 1) begin
            check("ack",  int'(pos_ack), int'(h_ld[t-1] && !h_rst[t-1]));
            check("addr", int'(numberaddr), h_rst[t-1] ? 0 : h_addr[t-1]);
        end
        if (t >= 2) begin
            d  = int'(rom_val(h_addr[t-2]));
            ev = h_in[t-2] && !h_rst[t-2] && !h_rst[t-1] && (d != 0);
            check("valid", int'(pixel_valid), int'(ev));
            check("pixel", int'(pixel), ev ? d : 0);
        end
        x = 10'(sx); y = 10'(sy); active = sact; frame_start = sfs;
        pos_load = sld; pos_x = 10'(spx); pos_y = 10'(spy); rst = srst;

        ex  = (m_pending && sfs) ? m_pend_x : m_cur_x;
        ey  = (m_pending && sfs) ? m_pend_y : m_cur_y;
        hit = sact && sx >= ex && sx < ex + SW && sy >= ey && sy < ey + SH;
        ea  = hit ? (sy - ey) * SW + (sx - ex) : 0;
        h_in[t] = hit; h_addr[t] = ea; h_ld[t] = sld; h_rst[t] = srst;

        if (srst) begin
            m_cur_x = INIT_X; m_cur_y = INIT_Y;
            m_pend_x = 0; m_pend_y = 0; m_pending = 1'b0;
        end else begin
            if (m_pending && sfs) begin
                m_cur_x = m_pend_x; m_cur_y = m_pend_y; m_pending = 1'b0;
            end
            if (sld) begin
                m_pend_x = spx; m_pend_y = spy; m_pending = 1'b1;
            end
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int sx, input int sy, input bit sfs);
        step(sx, sy, 1'b1, sfs, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic load(input int lx, input int ly, input bit sfs);
        step(0, 0, 1'b1, sfs, 1'b1, lx, ly, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int bx, by, rx, ry;
        bit bfs, bld, brst, bact;
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(2);

        // Geometry at reset position, colour key
        px(310, 230, 0); px(329, 249, 0); px(330, 230, 0);
        px(315, 230, 0); px(316, 230, 0);
        step(316, 230, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);   // inactive
        idle(2);

        // Single move applied at frame start
        load(100, 50, 0); px(100, 50, 0); px(310, 230, 0);
        px(100, 50, 1); px(100, 50, 0); px(119, 69, 0); idle(2);

        // Two loads before frame start: only the last goes live
        load(100, 50, 0); load(200, 60, 0); px(100, 50, 0);
        px(200, 60, 1); px(100, 50, 0); px(205, 61, 0); idle(2);

        // Load coinciding with frame start
        load(100, 50, 0); idle(1);
        step(100, 50, 1'b1, 1'b1, 1'b1, 400, 400, 1'b0);
        px(400, 400, 0); px(105, 52, 0);
        px(400, 400, 1); px(419, 419, 0); idle(2);

        // Right edge: no wrap back to column 0
        load(630, 100, 0); px(639, 100, 1); px(0, 100, 0); px(639, 119, 0);
        idle(2);

        // Reset while pending discards the request and its ack
        load(10, 10, 0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        px(10, 10, 1); px(310, 230, 0); px(310, 230, 1);
        load(20, 20, 0);
        step(0, 0, 1'b0, 1'b0, 1'b1, 30, 30, 1'b1);     // load during reset
        px(30, 30, 1); px(310, 230, 0); idle(2);

        // Randomized traffic, coordinates biased around the sprite
        for (int i = 0; i < 2500; i++) begin
            bfs  = ($urandom_range(0, 19) == 0);
            bld  = ($urandom_range(0, 9) == 0);
            brst = ($urandom_range(0, 149) == 0);
            bact = ($urandom_range(0, 7) != 0);
            rx = (bfs && m_pending) ? m_pend_x : m_cur_x;
            ry = (bfs && m_pending) ? m_pend_y : m_cur_y;
            if ($urandom_range(0, 9) == 0) begin
                bx = $urandom_range(0, 1023);
                by = $urandom_range(0, 1023);
            end else begin
                bx = rx - 3 + $urandom_range(0, 26);
                by = ry - 3 + $urandom_range(0, 26);
                if (bx < 0) bx = 0;
                if (by < 0) by = 0;
                bx = bx % 1024;
                by = by % 1024;
            end
            step(bx, by, bact, bfs, bld, $urandom_range(0, 639),
                 $urandom_range(0, 479), brst);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_digit_sprite_renderer
`default_nettype wire
